// File: rtl/serial_sub_ctrl_if.sv
// Requester-side bundle of the bit-serial subtractor: start/operands in, busy/done/result out.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell iterated LSB first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_sub_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, bout_q;
  logic             cell_d, cell_b;
  logic             accept, last;

  // Shared 1-bit full subtractor cell: A - B - C
  assign cell_d = a_q[0] ^ b_q[0] ^ borrow_q;
  assign cell_b = (~a_q[0] & (b_q[0] | borrow_q)) | (b_q[0] & borrow_q);

  // New DIFF enters at the top; after the last bit this is the full result
  assign res_sh = {cell_d, res_q};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE:  if (bus.start) begin
               accept  = 1'b1;
               state_d = SHIFT;
             end
      SHIFT: if (cnt_q == CW'(WIDTH-1)) begin
               last    = 1'b1;
               state_d = DONE;
             end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      res_q    <= '0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else if (accept) begin
      a_q      <= bus.a;
      b_q      <= bus.b;
      borrow_q <= bus.bin;
      cnt_q    <= '0;
    end else if (state_q == SHIFT) begin
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      borrow_q <= cell_b;
      res_q    <= res_sh[WIDTH-1:1];
      cnt_q    <= cnt_q + 1'b1;
      if (last) begin
        diff_q <= res_sh;
        bout_q <= cell_b;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out of a_q/b_q, so keep them aside
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
    end else if (last) begin
      ovf_q   <= (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule
